// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
//
// Watches a free-running 4-bit counter, one sample per clock.
// - Counts wraps (a 4'hF -> 4'h0 step).
// - Counts sequence errors (any step other than +1 mod 16).
// - Every WRAP_TARGET wraps it emits one report through a valid/ready handshake.
//   The report carries the cumulative wrap total (mod 256) and the window's
//   error count (saturating at 4'hF).
// - If a report falls due while the previous one is still pending, the new
//   report is dropped and the sticky overrun flag is raised.
//
// Parameters
//   WRAP_TARGET : wraps per report window, legal range 1..255
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   monitoring enable; low returns the FSM to IDLE
//   clear      in   synchronous clear of accumulators, flags and pending report
//   count_in   in   [3:0] sampled counter value
//   rpt_valid  out  report available
//   rpt_ready  in   downstream accepts the report
//   rpt_wraps  out  [7:0] cumulative wrap total at report time
//   rpt_errors out  [3:0] sequence errors in the reported window (saturating)
//   overrun    out  sticky: a report was dropped while one was pending
// -----------------------------------------------------------------------------
module count_wrap_monitor #(
  parameter int unsigned WRAP_TARGET = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] count_in,
  output logic       rpt_valid,
  input  logic       rpt_ready,
  output logic [7:0] rpt_wraps,
  output logic [3:0] rpt_errors,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Window index at which the next wrap closes the window.
  localparam logic [7:0] LP_LAST_IDX = 8'(WRAP_TARGET - 1);

  state_t     r_state;
  logic [3:0] r_prev;
  logic [7:0] r_win_cnt;
  logic [3:0] r_win_err;
  logic [7:0] r_total_wraps;
  logic       r_rpt_valid;
  logic [7:0] r_rpt_wraps;
  logic [3:0] r_rpt_errors;
  logic       r_overrun;

  logic       w_in_run;
  logic [3:0] w_expected;
  logic       w_wrap;
  logic       w_seq_err;
  logic [3:0] w_err_acc;
  logic       w_due;
  logic [7:0] w_wraps_inc;
  logic       w_xfer;

  // Samples are only judged in RUN with enable still high. Dropping enable
  // ends monitoring at that edge, so that edge's sample is not evaluated.
  assign w_in_run    = (r_state == ST_RUN) && enable;
  assign w_expected  = r_prev + 4'd1;  // 4-bit add: F+1 = 0, so a wrap is not an error
  assign w_wrap      = w_in_run && (r_prev == 4'hF) && (count_in == 4'h0);
  assign w_seq_err   = w_in_run && (count_in != w_expected);
  // Window error count with this cycle's error included, saturating at F.
  assign w_err_acc   = (w_seq_err && (r_win_err != 4'hF)) ? (r_win_err + 4'd1) : r_win_err;
  assign w_due       = w_wrap && (r_win_cnt == LP_LAST_IDX);
  assign w_wraps_inc = r_total_wraps + 8'd1;
  assign w_xfer      = r_rpt_valid && rpt_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_prev        <= 4'h0;
      r_win_cnt     <= 8'd0;
      r_win_err     <= 4'h0;
      r_total_wraps <= 8'd0;
      r_rpt_valid   <= 1'b0;
      r_rpt_wraps   <= 8'h00;
      r_rpt_errors  <= 4'h0;
      r_overrun     <= 1'b0;
    end else if (clear) begin
      r_state       <= ST_IDLE;
      r_win_cnt     <= 8'd0;
      r_win_err     <= 4'h0;
      r_total_wraps <= 8'd0;
      r_rpt_valid   <= 1'b0;
      r_rpt_wraps   <= 8'h00;
      r_rpt_errors  <= 4'h0;
      r_overrun     <= 1'b0;
    end else begin
      // Report handshake runs in every state, so a pending report can still
      // drain while the FSM sits in IDLE.
      if (w_due) begin
        if (!r_rpt_valid || rpt_ready) begin
          // Either the slot is free or the held report leaves on this edge:
          // load the new report and keep (or raise) valid.
          r_rpt_valid  <= 1'b1;
          r_rpt_wraps  <= w_wraps_inc;
          r_rpt_errors <= w_err_acc;
        end else begin
          // Slot still occupied: keep the held report, flag the loss.
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_rpt_valid <= 1'b0;
      end

      if (!enable) begin
        r_state   <= ST_IDLE;
        r_win_cnt <= 8'd0;
        r_win_err <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_PRIME;
          end
          ST_PRIME: begin
            // Seed the reference so the first RUN sample is judged against it.
            r_prev  <= count_in;
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            r_prev    <= count_in;
            r_win_err <= w_due ? 4'h0 : w_err_acc;
            if (w_wrap) begin
              r_total_wraps <= w_wraps_inc;
              r_win_cnt     <= w_due ? 8'd0 : (r_win_cnt + 8'd1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rpt_valid  = r_rpt_valid;
  assign rpt_wraps  = r_rpt_wraps;
  assign rpt_errors = r_rpt_errors;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
//
// Directed bench for count_wrap_monitor with two instances:
// - u_dut2 (WRAP_TARGET=2) covers the window, handshake, overrun, enable,
//   clear and reset behaviour.
// - u_dut1 (WRAP_TARGET=1) covers wrap-total rollover and error saturation.
//
// Expected reports are queued when the due wrap sample is driven. They are
// compared against the DUT when a transfer (valid && ready) is seen just
// before the clock edge.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;

  typedef struct packed {
    logic [7:0] wraps;
    logic [3:0] errors;
  } exp_t;

  logic       clock;
  logic       reset;

  logic       en2, clr2, rdy2, vld2, ov2;
  logic [3:0] cin2, er2;
  logic [7:0] wr2;

  logic       en1, clr1, rdy1, vld1, ov1;
  logic [3:0] cin1, er1;
  logic [7:0] wr1;

  logic [3:0] cnt2;
  logic [3:0] cnt1;

  exp_t q2[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  count_wrap_monitor #(.WRAP_TARGET(2)) u_dut2 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en2),
    .clear      (clr2),
    .count_in   (cin2),
    .rpt_valid  (vld2),
    .rpt_ready  (rdy2),
    .rpt_wraps  (wr2),
    .rpt_errors (er2),
    .overrun    (ov2)
  );

  count_wrap_monitor #(.WRAP_TARGET(1)) u_dut1 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en1),
    .clear      (clr1),
    .count_in   (cin1),
    .rpt_valid  (vld1),
    .rpt_ready  (rdy1),
    .rpt_wraps  (wr1),
    .rpt_errors (er1),
    .overrun    (ov1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push2(input logic [7:0] w, input logic [3:0] e);
    exp_t x;
    x.wraps  = w;
    x.errors = e;
    q2.push_back(x);
  endtask

  task automatic push1(input logic [7:0] w, input logic [3:0] e);
    exp_t x;
    x.wraps  = w;
    x.errors = e;
    q1.push_back(x);
  endtask

  // Compare any transfer about to happen on the next edge, then advance.
  task automatic tick();
    exp_t x;
    if (vld2 && rdy2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_report", {31'd0, vld2}, 32'd0);
      end else begin
        x = q2.pop_front();
        chk("dut2_rpt_wraps", {24'd0, wr2}, {24'd0, x.wraps});
        chk("dut2_rpt_errors", {28'd0, er2}, {28'd0, x.errors});
        $display("dut2 report transfer: wraps=%0h errors=%0h", wr2, er2);
      end
    end
    if (vld1 && rdy1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_report", {31'd0, vld1}, 32'd0);
      end else begin
        x = q1.pop_front();
        chk("dut1_rpt_wraps", {24'd0, wr1}, {24'd0, x.wraps});
        chk("dut1_rpt_errors", {28'd0, er1}, {28'd0, x.errors});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic feed2(input logic [3:0] v);
    cin2 = v;
    cnt2 = v + 4'd1;
    tick();
  endtask

  task automatic feed1(input logic [3:0] v);
    cin1 = v;
    cnt1 = v + 4'd1;
    tick();
  endtask

  // Feed the running ramp up to and including 4'hF.
  task automatic ramp2_to_f();
    do feed2(cnt2); while (cin2 != 4'hF);
  endtask

  task automatic ramp1_to_f();
    do feed1(cnt1); while (cin1 != 4'hF);
  endtask

  initial begin
    reset = 1'b0;
    en2 = 1'b0; clr2 = 1'b0; rdy2 = 1'b0; cin2 = 4'h0; cnt2 = 4'h0;
    en1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b0; cin1 = 4'h0; cnt1 = 4'h0;

    repeat (2) @(posedge clock);
    #1;
    chk("reset_rpt_valid", {31'd0, vld2}, 32'd0);
    chk("reset_rpt_wraps", {24'd0, wr2}, 32'd0);
    chk("reset_rpt_errors", {28'd0, er2}, 32'd0);
    chk("reset_overrun", {31'd0, ov2}, 32'd0);
    chk("reset_dut1_rpt_valid", {31'd0, vld1}, 32'd0);
    reset = 1'b1;

    // A: clean ramp, two wraps, single-cycle report pulse
    en2 = 1'b1; rdy2 = 1'b1;
    ramp2_to_f();
    feed2(4'h0);
    chk("A_no_report_after_wrap1", {31'd0, vld2}, 32'd0);
    ramp2_to_f();
    chk("A_valid_low_before_due", {31'd0, vld2}, 32'd0);
    push2(8'h02, 4'h0);
    feed2(4'h0);
    chk("A_valid_latency", {31'd0, vld2}, 32'd1);
    chk("A_rpt_wraps", {24'd0, wr2}, 32'h02);
    chk("A_rpt_errors", {28'd0, er2}, 32'h0);
    feed2(cnt2);
    chk("A_single_cycle_pulse", {31'd0, vld2}, 32'd0);

    // B: clear, then a window with one 3->7 jump, then a clean window
    clr2 = 1'b1;
    feed2(cnt2);
    clr2 = 1'b0;
    chk("B_clear_valid", {31'd0, vld2}, 32'd0);
    chk("B_clear_overrun", {31'd0, ov2}, 32'd0);
    ramp2_to_f();
    feed2(4'h0);
    feed2(4'h1); feed2(4'h2); feed2(4'h3); feed2(4'h7);
    ramp2_to_f();
    push2(8'h02, 4'h1);
    feed2(4'h0);
    chk("B_win1_rpt_errors", {28'd0, er2}, 32'h1);
    chk("B_win1_rpt_wraps", {24'd0, wr2}, 32'h02);
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    push2(8'h04, 4'h0);
    feed2(4'h0);
    chk("B_win2_rpt_errors", {28'd0, er2}, 32'h0);
    chk("B_win2_rpt_wraps", {24'd0, wr2}, 32'h04);
    feed2(cnt2);

    // C: ready low across two windows -> held report, overrun
    clr2 = 1'b1;
    feed2(cnt2);
    clr2 = 1'b0;
    rdy2 = 1'b0;
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    push2(8'h02, 4'h0);
    feed2(4'h0);
    chk("C_first_valid", {31'd0, vld2}, 32'd1);
    chk("C_no_overrun_yet", {31'd0, ov2}, 32'd0);
    ramp2_to_f();
    chk("C_held_valid", {31'd0, vld2}, 32'd1);
    chk("C_held_wraps", {24'd0, wr2}, 32'h02);
    feed2(4'h0);
    ramp2_to_f();
    feed2(4'h0);
    chk("C_overrun_set", {31'd0, ov2}, 32'd1);
    chk("C_held_wraps_after_drop", {24'd0, wr2}, 32'h02);
    chk("C_held_errors_after_drop", {28'd0, er2}, 32'h0);
    rdy2 = 1'b1;
    feed2(cnt2);
    chk("C_valid_drop_after_xfer", {31'd0, vld2}, 32'd0);
    chk("C_overrun_sticky", {31'd0, ov2}, 32'd1);

    // D: ready rises exactly in the second due cycle -> back-to-back
    clr2 = 1'b1;
    rdy2 = 1'b0;
    feed2(cnt2);
    clr2 = 1'b0;
    chk("D_clear_overrun", {31'd0, ov2}, 32'd0);
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    push2(8'h02, 4'h0);
    feed2(4'h0);
    chk("D_first_valid", {31'd0, vld2}, 32'd1);
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    rdy2 = 1'b1;
    push2(8'h04, 4'h0);
    feed2(4'h0);
    chk("D_valid_stays", {31'd0, vld2}, 32'd1);
    chk("D_second_wraps", {24'd0, wr2}, 32'h04);
    chk("D_no_overrun", {31'd0, ov2}, 32'd0);
    feed2(cnt2);
    chk("D_valid_low_after", {31'd0, vld2}, 32'd0);

    // E: enable drop mid-window, clear with pending report, reset
    clr2 = 1'b1;
    feed2(cnt2);
    clr2 = 1'b0;
    ramp2_to_f();
    feed2(4'h0);
    feed2(cnt2);
    en2 = 1'b0;
    feed2(cnt2);
    en2 = 1'b1;
    ramp2_to_f();
    feed2(4'h0);
    chk("E_window_restarted", {31'd0, vld2}, 32'd0);
    ramp2_to_f();
    push2(8'h03, 4'h0);
    feed2(4'h0);
    chk("E_total_retained", {24'd0, wr2}, 32'h03);
    feed2(cnt2);
    ramp2_to_f();
    feed2(4'h0);
    rdy2 = 1'b0;
    ramp2_to_f();
    feed2(4'h0);
    chk("E_pending_before_clear", {31'd0, vld2}, 32'd1);
    clr2 = 1'b1;
    feed2(cnt2);
    clr2 = 1'b0;
    chk("E_clear_valid", {31'd0, vld2}, 32'd0);
    chk("E_clear_wraps", {24'd0, wr2}, 32'h00);
    chk("E_clear_errors", {28'd0, er2}, 32'h0);
    chk("E_clear_overrun", {31'd0, ov2}, 32'd0);
    rdy2 = 1'b1;
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    push2(8'h02, 4'h0);
    feed2(4'h0);
    chk("E_total_cleared", {24'd0, wr2}, 32'h02);
    feed2(cnt2);
    rdy2 = 1'b0;
    ramp2_to_f();
    feed2(4'h0);
    ramp2_to_f();
    feed2(4'h0);
    chk("E_pending_before_reset", {31'd0, vld2}, 32'd1);
    reset = 1'b0;
    #2;
    chk("E_reset_valid", {31'd0, vld2}, 32'd0);
    chk("E_reset_wraps", {24'd0, wr2}, 32'h00);
    chk("E_reset_errors", {28'd0, er2}, 32'h0);
    chk("E_reset_overrun", {31'd0, ov2}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    rdy2 = 1'b1;
    ramp2_to_f();
    feed2(4'h0);
    chk("E_no_report_after_reset", {31'd0, vld2}, 32'd0);
    ramp2_to_f();
    chk("E_still_no_report", {31'd0, vld2}, 32'd0);
    en2 = 1'b0;

    // F: WRAP_TARGET=1, 256 wraps, then error saturation
    en1 = 1'b1; rdy1 = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      ramp1_to_f();
      push1(8'(k), 4'h0);
      feed1(4'h0);
      if (k == 256) begin
        chk("F_last_wraps_rollover", {24'd0, wr1}, 32'h00);
      end
    end
    $display("dut1 completed 256 wrap windows");
    repeat (20) feed1(4'h5);
    ramp1_to_f();
    push1(8'h01, 4'hF);
    feed1(4'h0);
    chk("F_errors_saturated", {28'd0, er1}, 32'hF);
    feed1(cnt1);
    chk("F_valid_low_after", {31'd0, vld1}, 32'd0);

    chk("dut2_all_reports_seen", q2.size(), 32'd0);
    chk("dut1_all_reports_seen", q1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter: WRAP_TARGET, default 4, number of count wraps per report window (legal 1..255).
REQ-002 Port: clock  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: enable  input  1  monitoring enable; low returns the block to IDLE.
REQ-005 Port: clear  input  1  synchronous clear of all accumulators, sticky flags and the pending report.
REQ-006 Port: count_in  input  4  free-running counter value from the upstream counter stage, one sample per clock.
REQ-007 Port: rpt_valid  output  1  report available.
REQ-008 Port: rpt_ready  input  1  downstream accepts the report; transfer occurs when rpt_valid and rpt_ready are both 1.
REQ-009 Port: rpt_wraps  output  8  cumulative wrap total at report time, modulo 256.
REQ-010 Port: rpt_errors  output  4  sequence errors in the reported window, saturating at 4'hF.
REQ-011 Port: overrun  output  1  sticky: a report was dropped because the previous one was still pending.

Function
REQ-012 FSM states: IDLE, PRIME, RUN.
REQ-013 IDLE->PRIME when enable=1; PRIME->RUN on the next cycle with enable=1; any state->IDLE on the cycle after enable=0.
REQ-014 PRIME captures count_in into prev; no comparison is made in PRIME.
REQ-015 RUN, every cycle: prev <= count_in.
REQ-016 RUN, wrap event: prev=4'hF and count_in=4'h0.
REQ-017 RUN, sequence error: count_in != (prev+1) mod 16; a 4'hF->4'h0 step is not an error.
REQ-018 Each error increments win_err, saturating at 4'hF; each wrap increments total_wraps (8-bit, 255->0) and win_cnt.
REQ-019 Report due: a wrap event while win_cnt = WRAP_TARGET-1; in that cycle win_cnt <= 0 and win_err <= 0.
REQ-020 Report latency: rpt_valid rises on the cycle after the due wrap sample.
REQ-021 Report contents: rpt_wraps = incremented total_wraps; rpt_errors = win_err including an error detected in the due cycle (saturated).
REQ-022 While rpt_valid=1 and rpt_ready=0, rpt_wraps and rpt_errors are held stable.
REQ-023 rpt_valid=1 and rpt_ready=1 with no new report due: rpt_valid <= 0 on the next cycle.
REQ-024 New report due with rpt_valid=1 and rpt_ready=0: new report dropped, held report unchanged, overrun <= 1.
REQ-025 New report due with rpt_valid=1 and rpt_ready=1 in the same cycle: held report transferred, new report loaded, rpt_valid stays 1, no overrun.
REQ-026 enable=0: win_cnt and win_err cleared; total_wraps, any pending report and overrun retained; the handshake continues to operate in IDLE.
REQ-027 clear=1 has priority over all other events except reset: total_wraps, win_cnt, win_err, rpt_valid and overrun <= 0; FSM -> IDLE.
REQ-028 An error in the first RUN cycle is evaluated against the PRIME sample.

Reset
REQ-029 Async assertion, at reset low: FSM=IDLE; prev=4'h0; win_cnt=0; win_err=0; total_wraps=0; rpt_valid=0; rpt_wraps=8'h00; rpt_errors=4'h0; overrun=0.
REQ-030 Reset deasserts synchronously to clock; the first state transition occurs on the first rising edge after release.
REQ-031 Reset mid-window or while a report is pending discards all state; no report is emitted after release.

Verification (WRAP_TARGET=2 unless stated)
REQ-032 enable=1, rpt_ready=1, clean 0..F ramp for 2 wraps -> single 1-cycle rpt_valid pulse one cycle after the second 4'hF->4'h0 step, rpt_wraps=8'h02, rpt_errors=0.
REQ-033 Ramp with count_in jumping 4'h3->4'h7 once inside window 1 -> rpt_errors=4'h1, rpt_wraps=8'h02; next window reports rpt_errors=0.
REQ-034 rpt_ready=0 across 2 windows -> first report held (rpt_wraps=8'h02), overrun=1 after the second due wrap; rpt_ready=1 -> transfer, rpt_valid=0 on the next cycle.
REQ-035 rpt_ready asserted exactly in the cycle the second report is due -> back-to-back transfers, rpt_wraps 8'h02 then 8'h04, overrun stays 0.
REQ-036 WRAP_TARGET=1, 256 clean wraps -> 256 reports, last rpt_wraps=8'h00; 20 erroneous samples in one window -> rpt_errors=4'hF.
REQ-037 enable dropped mid-window, then clear=1, then reset pulsed with a report pending -> win_cnt restarts at 0; clear zeroes all state; after reset all outputs are at reset values and no report is emitted.
